int_sram_resp: RTL
==================

# int_sram_resp

Responder side of the internal SRAM native interface. Accepts the boot controller's free-running write stream, which is never back-pressured, and CPU native requests. The boot port has absolute priority. The block drives a single-port word array and returns `cpu_rdata`/`cpu_ready`. It sits between the boot controller, the CPU data/instruction interconnect and the internal SRAM.

## Interface
Parameters:
- `DATA_W`, 32, data width in bits; byte-strobe width is `DATA_W/8`.
- `ADDR_W`, 14, byte address width; depth is `2**(ADDR_W-2)` words.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `boot_valid`  in  1  boot write request; may be high every cycle.
- `boot_addr`  in  `ADDR_W`  byte address; word index `boot_addr[ADDR_W-1:2]`.
- `boot_wdata`  in  `DATA_W`  write data.
- `boot_wstrb`  in  `DATA_W/8`  byte enables.
- `cpu_valid`  in  1  one-cycle request pulse.
- `cpu_addr`  in  `ADDR_W`  byte address.
- `cpu_wdata`  in  `DATA_W`  write data.
- `cpu_wstrb`  in  `DATA_W/8`  byte enables; all-zero means read.
- `cpu_rdata`  out  `DATA_W`  read data, valid with `cpu_ready`.
- `cpu_ready`  out  1  one-cycle completion pulse.
- `boot_wcnt`  out  `ADDR_W-1`  count of boot words written since reset; saturating.
- `boot_csum`  out  `DATA_W`  boot-data checksum (see Configuration).

## Operation
- **Word index:** bits `[ADDR_W-1:2]` of either port's address select the word. Upper bits are truncated, so addresses wrap modulo depth. Bits `[1:0]` are ignored.
- **Boot write:** when `boot_valid` and `|boot_wstrb`, enabled bytes are written that cycle and `boot_wcnt` increments. `boot_wcnt` holds at all-ones.
  - `boot_valid` with `boot_wstrb==0`: no write, no count.
- **States:** `IDLE`, `PEND`, `ACK`.
  - `IDLE`, `cpu_valid`, `boot_valid==0`: access the array this cycle (write enabled bytes, or read the word), go to `ACK`.
  - `IDLE`, `cpu_valid`, `boot_valid==1`: latch addr/wdata/wstrb into the pending register, go to `PEND`.
  - `PEND`: execute the latched access on the first cycle with `boot_valid==0`, go to `ACK`. Otherwise stay in `PEND`.
  - `ACK`: `cpu_ready=1`. A new `cpu_valid` here is handled exactly as in `IDLE`, which allows back-to-back requests. Otherwise return to `IDLE`.
- `cpu_valid` while in `PEND` is a protocol violation. It is ignored and the pending request is kept.
- **Read data:**
  - A read loads `cpu_rdata` with the word.
  - A write leaves `cpu_rdata` unchanged.
  - `cpu_rdata` holds between reads.
- **Same-word hazard:** a CPU read of a word written by the boot port in an earlier cycle returns the new data. There is no same-cycle collision, because boot always wins.
- **Memory contents** are not reset.
- **Reset mid-operation:** any pending or in-flight CPU request is dropped, with no `cpu_ready`.

## Timing
- Reset values:
  - state `IDLE`
  - `cpu_ready=0`
  - `cpu_rdata=0`
  - `boot_wcnt=0`
  - `boot_csum=0`
  - pending register cleared
- **Unstalled latency:** request at cycle t, `cpu_ready` and data at t+1, high for exactly one cycle.
- **Stalled:** request at t, boot busy t..t+n-1, access at t+n, `cpu_ready` at t+n+1.
- **Boot writes:** effective at the clock edge ending the request cycle, with no back-pressure. `boot_wcnt` updates that same edge.
- **Throughput:** one CPU access per cycle when the boot port is idle.

## Configuration
- `SRAM_BOOT_CSUM_EN` defined:
  - `boot_csum` accumulates modulo `2**DATA_W` the sum of `boot_wdata` for every counted boot write whose `boot_wstrb` is all-ones.
  - Partial-strobe writes are counted but not summed.
  - It is cleared only by `rst`.
- Undefined: no accumulator is synthesized and `boot_csum` is tied to 0.

## Test plan
- **Reset:** `rst` pulse mid-stream -> all outputs 0; `cpu_ready` never asserts for the aborted request.
- **Boot load:** 16 consecutive boot writes, addr 0x0..0x3C, data 0x100+i, strb 0xF, then CPU reads of 0x0 and 0x3C.
  - -> `boot_wcnt=16`.
  - -> `cpu_rdata` 0x100 then 0x10F, each `cpu_ready` one cycle after the request.
  - -> with `SRAM_BOOT_CSUM_EN`, `boot_csum=0x1078`.
- **Collision:** CPU read of 0x8 issued on a cycle with `boot_valid=1`, 3 more boot cycles follow -> `cpu_ready` exactly 5 cycles after the request, data equal to the boot-written value.
- **Byte strobes:** CPU write 0xAABBCCDD strb 0xF to 0x20, then 0x11223344 strb 0x5, then read -> 0xAA22CC44; `cpu_rdata` unchanged after the writes.
- **Wrap and saturation:**
  - boot write to byte address `2**ADDR_W` -> word 0 updated.
  - `2**(ADDR_W-1)` boot writes -> `boot_wcnt` stays all-ones.
- **Back-to-back:** CPU reads on 4 consecutive cycles, boot idle -> `cpu_ready` high 4 consecutive cycles with correct data in order.

Source files
------------

// File: rtl/int_sram_resp.sv
// int_sram_resp
// Responder side of the internal SRAM native interface. The boot
// controller streams writes into a single-port word array and is never
// back-pressured. CPU requests are served whenever the boot port is idle.
// A CPU request that arrives while the boot port is busy is parked in a
// pending register. It is executed on the first boot-idle cycle.
//
// Optional feature macro: SRAM_BOOT_CSUM_EN
//   defined   : boot_csum accumulates boot_wdata of full-strobe boot writes
//   undefined : no accumulator, boot_csum is tied to 0
//
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   boot_valid/addr/wdata/wstrb
//                          boot write stream, absolute priority
//   cpu_valid/addr/wdata/wstrb
//                          one-cycle CPU request, wstrb==0 means read
//   cpu_rdata              read data, valid with cpu_ready
//   cpu_ready              one-cycle completion pulse
//   boot_wcnt              saturating count of boot words written
//   boot_csum              boot data checksum (0 when feature disabled)
module int_sram_resp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  boot_valid,
    input  logic [ADDR_W-1:0]     boot_addr,
    input  logic [DATA_W-1:0]     boot_wdata,
    input  logic [DATA_W/8-1:0]   boot_wstrb,
    input  logic                  cpu_valid,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic [DATA_W-1:0]     cpu_wdata,
    input  logic [DATA_W/8-1:0]   cpu_wstrb,
    output logic [DATA_W-1:0]     cpu_rdata,
    output logic                  cpu_ready,
    output logic [ADDR_W-2:0]     boot_wcnt,
    output logic [DATA_W-1:0]     boot_csum
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = ADDR_W - 2;
    localparam int DEPTH  = 2 ** IDX_W;

    typedef enum logic [1:0] {IDLE, PEND, ACK} state_t;

    state_t              state;
    state_t              state_nxt;

    logic [IDX_W-1:0]    pend_idx;
    logic [DATA_W-1:0]   pend_wdata;
    logic [STRB_W-1:0]   pend_wstrb;

    logic                latch_req;
    logic                acc_en;
    logic [IDX_W-1:0]    acc_idx;
    logic [DATA_W-1:0]   acc_wdata;
    logic [STRB_W-1:0]   acc_wstrb;

    logic                boot_we;
    logic [IDX_W-1:0]    boot_idx;

    logic [DATA_W-1:0]   mem [DEPTH];

    // Byte-offset address bits carry no meaning for a word array.
    logic                unused_addr_lsbs;
    assign unused_addr_lsbs = ^{boot_addr[1:0], cpu_addr[1:0]};

    // A boot request with no enabled bytes writes nothing and is not counted.
    // It still occupies the array port, so it stalls the CPU like any other
    // boot cycle.
    assign boot_we   = boot_valid & (|boot_wstrb);
    assign boot_idx  = boot_addr[ADDR_W-1:2];
    assign cpu_ready = (state == ACK);

    // Next-state logic. IDLE and ACK behave the same way, so a request can
    // arrive in the same cycle the previous one completes. In PEND the array
    // access comes from the parked request, and any new cpu_valid is dropped.
    always_comb begin
        state_nxt = state;
        latch_req = 1'b0;
        acc_en    = 1'b0;
        acc_idx   = cpu_addr[ADDR_W-1:2];
        acc_wdata = cpu_wdata;
        acc_wstrb = cpu_wstrb;
        case (state)
            IDLE, ACK: begin
                state_nxt = IDLE;
                if (cpu_valid) begin
                    if (boot_valid) begin
                        latch_req = 1'b1;
                        state_nxt = PEND;
                    end else begin
                        acc_en    = 1'b1;
                        state_nxt = ACK;
                    end
                end
            end
            PEND: begin
                acc_idx   = pend_idx;
                acc_wdata = pend_wdata;
                acc_wstrb = pend_wstrb;
                if (!boot_valid) begin
                    acc_en    = 1'b1;
                    state_nxt = ACK;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control state, pending request, read data and boot word counter.
    // A reset drops any parked request, so no cpu_ready is produced for it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pend_idx   <= '0;
            pend_wdata <= '0;
            pend_wstrb <= '0;
            cpu_rdata  <= '0;
            boot_wcnt  <= '0;
        end else begin
            state <= state_nxt;
            if (latch_req) begin
                pend_idx   <= cpu_addr[ADDR_W-1:2];
                pend_wdata <= cpu_wdata;
                pend_wstrb <= cpu_wstrb;
            end
            if (acc_en && (acc_wstrb == '0)) begin
                cpu_rdata <= mem[acc_idx];
            end
            if (boot_we && (boot_wcnt != '1)) begin
                boot_wcnt <= boot_wcnt + (ADDR_W-1)'(1);
            end
        end
    end

    // Word array, not reset. A CPU access only fires on boot-idle cycles, so
    // the two write sources never meet in the same cycle.
    always_ff @(posedge clk) begin
        for (int b = 0; b < STRB_W; b++) begin
            if (boot_we) begin
                if (boot_wstrb[b]) begin
                    mem[boot_idx][b*8 +: 8] <= boot_wdata[b*8 +: 8];
                end
            end else if (acc_en && acc_wstrb[b]) begin
                mem[acc_idx][b*8 +: 8] <= acc_wdata[b*8 +: 8];
            end
        end
    end

`ifdef SRAM_BOOT_CSUM_EN
    logic [DATA_W-1:0] csum_q;

    // Only full-word boot writes feed the checksum. Partial-strobe writes
    // are still counted in boot_wcnt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum_q <= '0;
        end else if (boot_we && (&boot_wstrb)) begin
            csum_q <= csum_q + boot_wdata;
        end
    end

    assign boot_csum = csum_q;
`else
    assign boot_csum = '0;
`endif

endmodule
